// File: rtl/tag_rsdp_par.sv
`default_nettype none
// tag_rsdp_par -- RSDP tag inner product u = e + sum(ch_i*s_i) over GF(2^W-1), L coordinates per cycle.
// Optional macro TAG_RSDP_CANON_EN maps an all-ones final result to 0. Rev 1.0
module tag_rsdp_par #(
    parameter int W  = 7,
    parameter int N  = 34,
    parameter int L  = 1,
    parameter int KB = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sel_a,
    input  logic                sel_y,
    input  logic [N*W-1:0]      b,
    input  logic [N*W-1:0]      a,
    input  logic [N*(KB+1)-1:0] x,
    input  logic [N*(KB+1)-1:0] y,
    input  logic [W-1:0]        e,
    output logic                busy,
    output logic                done,
    output logic [W-1:0]        u
);
    localparam int SW    = KB + 1;
    localparam int STEPS = N / L;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N*W-1:0]  ch_q;
    logic [N*SW-1:0] sec_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    u_q;
    logic [W-1:0]    u_d;
    logic [W-1:0]    u_fin_d;
    logic [W-1:0]    t_d;
    logic            busy_q;
    logic            done_q;

    // End-around carry: the sum of two W-bit values never carries twice.
    function automatic logic [W-1:0] eac_add(input logic [W-1:0] p, input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, p} + {1'b0, q};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [KB-1:0] k);
        logic [2*W-1:0] dbl;
        int unsigned    r;
        r   = 32'(k) % 32'(W);
        dbl = {v, v} << r;
        return dbl[2*W-1:W];
    endfunction

    always_comb begin
        u_d = u_q;
        t_d = '0;
        for (int j = 0; j < L; j++) begin
            t_d = rotl(ch_q[j*W +: W], sec_q[j*SW +: KB]);
            if (sec_q[j*SW + KB]) begin
                t_d = ~t_d;
            end
            u_d = eac_add(u_d, t_d);
        end
    end

`ifdef TAG_RSDP_CANON_EN
    assign u_fin_d = (u_d == {W{1'b1}}) ? '0 : u_d;
`else
    assign u_fin_d = u_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            sec_q   <= '0;
            cnt_q   <= '0;
            u_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    ch_q  <= ch_q >> (L*W);
                    sec_q <= sec_q >> (L*SW);
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        u_q     <= u_fin_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        u_q <= u_d;
                    end
                end
                default: begin
                    if (start) begin
                        ch_q    <= sel_a ? a : b;
                        sec_q   <= sel_y ? y : x;
                        u_q     <= e;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign u    = u_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_rsdp_par.sv
`default_nettype none
// tb_tag_rsdp_par -- directed and randomized checks of tag_rsdp_par at L=1 and L=2 against a modular-arithmetic model. Rev 1.0
module tb_tag_rsdp_par;
    localparam int W  = 7;
    localparam int N  = 34;
    localparam int KB = 3;
    localparam int SW = KB + 1;
    localparam int P  = (1 << W) - 1;
`ifdef TAG_RSDP_CANON_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sel_a;
    logic            sel_y;
    logic [N*W-1:0]  a;
    logic [N*W-1:0]  b;
    logic [N*SW-1:0] x;
    logic [N*SW-1:0] y;
    logic [W-1:0]    e;
    logic            busy1, done1, busy2, done2;
    logic [W-1:0]    u1, u2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tag_rsdp_par #(.W(W), .N(N), .L(1), .KB(KB)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_y(sel_y),
        .b(b), .a(a), .x(x), .y(y), .e(e), .busy(busy1), .done(done1), .u(u1));

    tag_rsdp_par #(.W(W), .N(N), .L(2), .KB(KB)) dut2 (
        .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_y(sel_y),
        .b(b), .a(a), .x(x), .y(y), .e(e), .busy(busy2), .done(done2), .u(u2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value-level model: zero is all-ones unless every operand was the all-zero pattern.
    function automatic logic [W-1:0] model(input logic [N*W-1:0] ch, input logic [N*SW-1:0] sc,
                                          input logic [W-1:0] ev);
        int unsigned acc, prod, c, k;
        bit          allzero;
        acc     = ev % P;
        allzero = (ev == 0);
        for (int i = 0; i < N; i++) begin
            c    = ch[i*W +: W];
            k    = sc[i*SW +: KB];
            prod = ((c % P) << k) % P;
            if (sc[i*SW + KB]) prod = (P - prod) % P;
            if (c != 0 || sc[i*SW + KB]) allzero = 1'b0;
            acc = (acc + prod) % P;
        end
        if (acc != 0) return W'(acc);
        if (CANON || allzero) return '0;
        return W'(P);
    endfunction

    function automatic logic [N*W-1:0] rand_ch();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [N*SW-1:0] rand_sec();
        logic [N*SW-1:0] r;
        for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'($urandom);
        return r;
    endfunction

    task automatic load(input logic [N*W-1:0] ch, input logic [N*SW-1:0] sc, input logic [W-1:0] ev);
        sel_a = 1'($urandom_range(0, 1));
        sel_y = 1'($urandom_range(0, 1));
        if (sel_a) begin a = ch; b = rand_ch(); end
        else       begin b = ch; a = rand_ch(); end
        if (sel_y) begin y = sc; x = rand_sec(); end
        else       begin x = sc; y = rand_sec(); end
        e = ev;
    endtask

    task automatic run_chk(input string tag, input logic [W-1:0] expv, input bit restart, input bit do_rst);
        int lat1, lat2, np1, np2;
        lat1 = -1; lat2 = -1; np1 = 0; np2 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int m = 0; m < 40; m++) begin
            if (restart && m == 5) start = 1'b1;
            if (restart && m == 6) start = 1'b0;
            if (do_rst && m == 10) begin
                rst = 1'b1;
                #1;
                chk({tag, " rst u1"}, 32'(u1), 32'd0);
                chk({tag, " rst busy1"}, 32'(busy1), 32'd0);
                chk({tag, " rst u2"}, 32'(u2), 32'd0);
                chk({tag, " rst busy2"}, 32'(busy2), 32'd0);
                rst = 1'b0;
            end
            if (!do_rst) begin
                chk({tag, " busy1"}, 32'(busy1), 32'(m < 34));
                chk({tag, " busy2"}, 32'(busy2), 32'(m < 17));
            end
            if (done1 === 1'b1) begin np1++; lat1 = m; end
            if (done2 === 1'b1) begin np2++; lat2 = m; end
            @(negedge clk);
        end
        if (do_rst) begin
            chk({tag, " no done1"}, 32'(np1), 32'd0);
            chk({tag, " no done2"}, 32'(np2), 32'd0);
        end else begin
            chk({tag, " lat1"}, 32'(lat1), 32'd34);
            chk({tag, " lat2"}, 32'(lat2), 32'd17);
            chk({tag, " pulses1"}, 32'(np1), 32'd1);
            chk({tag, " pulses2"}, 32'(np2), 32'd1);
            chk({tag, " u1"}, 32'(u1), 32'(expv));
            chk({tag, " u2"}, 32'(u2), 32'(expv));
        end
    endtask

    initial begin
        logic [N*W-1:0]  ch;
        logic [N*SW-1:0] sc;
        logic [W-1:0]    ev;

        rst = 1'b1; start = 1'b0; sel_a = 1'b0; sel_y = 1'b0;
        a = '0; b = '0; x = '0; y = '0; e = '0;
        repeat (2) @(negedge clk);
        chk("reset u1", 32'(u1), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset done1", 32'(done1), 32'd0);
        chk("reset u2", 32'(u2), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) ch[i*W +: W] = W'(1);
        sc = '0;
        load(ch, sc, '0);
        run_chk("ones", 7'h22, 1'b0, 1'b0);
        run_chk("ones restart", 7'h22, 1'b1, 1'b0);

        ch = '0; sc = '0;
        ch[0 +: W] = W'(3);
        sc[0 +: SW] = 4'b0010;
        load(ch, sc, 7'd1);
        run_chk("pos rot", 7'h0D, 1'b0, 1'b0);
        sc[0 +: SW] = 4'b1010;
        load(ch, sc, 7'd1);
        run_chk("neg rot", 7'h74, 1'b0, 1'b0);

        ch = '0; sc = '0;
        ch[0 +: W] = W'(5);
        ch[W +: W] = W'(5);
        sc[SW +: SW] = 4'b1000;
        load(ch, sc, '0);
        run_chk("cancel", CANON ? 7'h00 : 7'h7F, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) ch[i*W +: W] = W'(1);
        sc = '0;
        load(ch, sc, '0);
        run_chk("midrst", '0, 1'b0, 1'b1);
        run_chk("after rst", 7'h22, 1'b0, 1'b0);

        load(ch, sc, 7'd100);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 107; m++) begin
            chk("b2b done1", 32'(done1), 32'((m % 35) == 34));
            chk("b2b done2", 32'(done2), 32'((m % 18) == 17));
            if (done1 === 1'b1) chk("b2b u1", 32'(u1), 32'd7);
            if (done2 === 1'b1) chk("b2b u2", 32'(u2), 32'd7);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            ch = rand_ch();
            sc = rand_sec();
            ev = W'($urandom);
            load(ch, sc, ev);
            run_chk("random", model(ch, sc, ev), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
